sub8_serial: RTL and testbench

- Bit-serial 8-bit subtractor with borrow-in/borrow-out. Computes d = a - b - bin one bit per clock, LSB first, using a single 1-bit full-subtractor cell.
- Fronted by a valid/ready request port and a valid/ready result port.
- Counterpart to the team's combinational ripple adders. Used where area matters more than latency, and as the subtract path of the arithmetic test datapaths.

---
 rtl/sub_serial_pkg.sv | 27 ++
 rtl/full_sub1.sv | 14 +
 rtl/sub8_serial.sv | 115 +++++++++++
 tb/tb_sub8_serial.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sub_serial_pkg.sv
// Shared types and reference model for the bit-serial subtractor.
// Used by the RTL self-check and by the bench.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // Returns {bout, d} with d masked to w bits (w <= 32).
  function automatic logic [32:0] ref_sub(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        bin,
    input int unsigned w
  );
    logic [32:0] full;
    logic [31:0] mask;
    logic        bo;
    full = {1'b0, a} - {1'b0, b} - {32'b0, bin};
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    bo   = ({1'b0, a} < ({1'b0, b} + {32'b0, bin}));
    return {bo, full[31:0] & mask};
  endfunction

endpackage

// File: rtl/full_sub1.sv
// One-bit full subtractor cell.
// Combinational counterpart of full_adder1.
module full_sub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub8_serial.sv
// Bit-serial subtractor, LSB first, one full_sub1 cell.
// Valid/ready request and result ports.
module sub8_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  import sub_serial_pkg::*;

  localparam int CW = $clog2(WIDTH);

  sub_state_e state, state_n;

  logic [WIDTH-1:0] sa, sb, res;
  logic [WIDTH-1:0] ca, cb;
  logic             cbin;
  logic             br, boutr;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fd, fb;
  logic [32:0]      exp_ref;

  full_sub1 u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (fd),
    .bout (fb)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = BUSY;
      end
      BUSY: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    exp_ref = ref_sub(32'(ca), 32'(cb), cbin, WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      ca    <= '0;
      cb    <= '0;
      cbin  <= 1'b0;
      br    <= 1'b0;
      boutr <= 1'b0;
      cnt   <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        sa   <= a;
        sb   <= b;
        br   <= bin;
        ca   <= a;
        cb   <= b;
        cbin <= bin;
        cnt  <= '0;
      end else if (state == BUSY) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        br  <= fb;
        res <= {fd, res[WIDTH-1:1]};
        // Hold the counter on the last bit so it never wraps.
        if (last) boutr <= fb;
        else      cnt   <= cnt + 1'b1;
      end
      if (state == DONE) begin
        assert ({boutr, 32'(res)} == exp_ref)
          else $error("sub8_serial result differs from reference");
      end
    end
  end

  assign d    = res;
  assign bout = boutr;

endmodule

// File: tb/tb_sub8_serial.sv
// Directed and randomized bench for sub8_serial.
// Inputs driven and outputs sampled on the falling edge.
module tb_sub8_serial;

  import sub_serial_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;
  logic       bout;

  int checks;
  int errors;

  sub8_serial #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    int         stall;
    logic       churn;
    logic [7:0] ed;
    logic       eb;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic txn(input logic [7:0] ta, input logic [7:0] tb,
                     input logic tbin, input int stall,
                     input logic churn, input logic [7:0] ed,
                     input logic eb);
    int cyc;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a         = ta;
    b         = tb;
    bin       = tbin;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (churn) begin
        a         = 8'($urandom);
        b         = 8'($urandom);
        bin       = 1'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("latency", 32'(cyc), 32'd8);
    chk("d", 32'(d), 32'(ed));
    chk("bout", 32'(bout), 32'(eb));
    for (int i = 0; i < stall; i++) begin
      a        = 8'($urandom);
      b        = 8'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_d", 32'(d), 32'(ed));
      chk("stall_bout", 32'(bout), 32'(eb));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rbin;
    logic [32:0] r;
    int          wt;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;

    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    #20 rst_n = 1'b1;

    vecs[0] = '{8'h50, 8'h20, 1'b0, 0, 1'b0, 8'h30, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 0, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h05, 8'h05, 1'b1, 1, 1'b0, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 0, 1'b0, 8'hFE, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 1'b0, 5, 1'b0, 8'h01, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 2, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 0, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 0, 1'b1, 8'hFF, 1'b1};
    vecs[8] = '{8'h7F, 8'h80, 1'b0, 3, 1'b1, 8'hFF, 1'b1};
    vecs[9] = '{8'hA5, 8'h5A, 1'b1, 0, 1'b1, 8'h4A, 1'b0};

    foreach (vecs[i])
      txn(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].stall,
          vecs[i].churn, vecs[i].ed, vecs[i].eb);

    // Async reset three cycles into BUSY, between clock edges.
    @(negedge clk);
    a        = 8'h00;
    b        = 8'h01;
    bin      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_d", 32'(d), 32'd0);
    chk("arst_bout", 32'(bout), 32'd0);
    #1 rst_n = 1'b1;
    txn(8'h10, 8'h03, 1'b0, 0, 1'b0, 8'h0D, 1'b0);

    // Reset while DONE discards the pending result.
    @(negedge clk);
    a        = 8'h01;
    b        = 8'h02;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wt = 0;
    while (!out_valid && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    chk("done_reached", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("drst_out_valid", 32'(out_valid), 32'd0);
    chk("drst_d", 32'(d), 32'd0);
    #1 rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      r    = ref_sub(32'(ra), 32'(rb), rbin, 8);
      txn(ra, rb, rbin, $urandom_range(0, 2), 1'($urandom),
          r[7:0], r[32]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
